lt24_layer_streamer: RTL and testbench

//  Hardware frame pusher for the LT24 LCD. Composites a scaled background layer and one

---
 rtl/lt24_layer_streamer_pkg.sv | 23 ++
 rtl/lt24_layer_streamer_if.sv | 11 +
 rtl/lt24_wr_timer.sv | 57 +++++
 rtl/lt24_layer_streamer.sv | 237 +++++++++++++++++++++++
 tb/tb_lt24_layer_streamer.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lt24_layer_streamer_pkg.sv
// Shared types and constants for the LT24 layer streamer.
package lt24_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEQ    = 3'd1,
    PADDR  = 3'd2,
    PWAIT  = 3'd3,
    PWR_LO = 3'd4,
    PWR_HI = 3'd5,
    FIN    = 3'd6
  } state_t;

  // LT24 (ILI9341) command opcodes.
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  // Number of header words sent before the pixel stream.
  localparam int HDR_LEN = 11;

endpackage

// File: rtl/lt24_layer_streamer_if.sv
// LT24 8080-style write bus. The streamer is the master; the panel is the slave.
interface lt24_layer_streamer_if;
  logic        lt24_cs;
  logic        lt24_rs;
  logic        lt24_rd;
  logic        lt24_wr;
  logic [15:0] lt24_data;

  modport master (output lt24_cs, lt24_rs, lt24_rd, lt24_wr, lt24_data);
  modport slave  (input  lt24_cs, lt24_rs, lt24_rd, lt24_wr, lt24_data);
endinterface

// File: rtl/lt24_wr_timer.sv
// Write-strobe generator for one LT24 bus word.
// A load starts a word: wr falls on the next cycle with data/rs valid, stays
// low for WR_LO_CYC cycles, then high for WR_HI_CYC cycles with data held.
// word_done marks the last high cycle so the next load can follow back-to-back.
module lt24_wr_timer #(
  parameter int WR_LO_CYC = 2,
  parameter int WR_HI_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        load_rs,
  input  logic [15:0] load_data,
  output logic        wr,
  output logic        rs,
  output logic [15:0] data,
  output logic        lo_done,
  output logic        word_done
);

  logic       active;
  logic       in_lo;
  logic [7:0] cnt;

  assign lo_done   = active && in_lo && (cnt == 8'd0);
  assign word_done = active && !in_lo && (cnt == 8'd0);

  // Phase counter: load wins, otherwise count down low then high phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      in_lo  <= 1'b0;
      cnt    <= 8'd0;
      wr     <= 1'b1;
      rs     <= 1'b1;
      data   <= 16'd0;
    end else if (load) begin
      active <= 1'b1;
      in_lo  <= 1'b1;
      cnt    <= 8'(WR_LO_CYC - 1);
      wr     <= 1'b0;
      rs     <= load_rs;
      data   <= load_data;
    end else if (active) begin
      if (cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end else if (in_lo) begin
        in_lo <= 1'b0;
        cnt   <= 8'(WR_HI_CYC - 1);
        wr    <= 1'b1;
      end else begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lt24_layer_streamer.sv
// LT24 frame pusher: header sequence, then background + chroma-keyed sprite
// composited per pixel and written straight onto the LT24 bus.
// Control handshake: start is a one-cycle request accepted only in IDLE without
// abort; busy is high from the following cycle until the cycle after FIN; done
// pulses for exactly one cycle in FIN. abort is latched and honoured at the end
// of the word currently on the bus.
module lt24_layer_streamer
  import lt24_pkg::*;
#(
  parameter int H_RES     = 240,
  parameter int V_RES     = 320,
  parameter int BG_SHIFT  = 2,
  parameter int BG_AW     = 13,
  parameter int SPR_WL2   = 6,
  parameter int SPR_HL2   = 6,
  parameter int RD_LAT    = 2,
  parameter int WR_LO_CYC = 2,
  parameter int WR_HI_CYC = 2
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       sprite_en,
  input  logic [8:0]                 sprite_x,
  input  logic [8:0]                 sprite_y,
  input  logic [15:0]                key_color,
  output logic                       busy,
  output logic                       done,
  output logic [BG_AW-1:0]           bg_address,
  output logic                       bg_chipselect,
  output logic                       bg_clken,
  input  logic [15:0]                bg_readdata,
  output logic [SPR_WL2+SPR_HL2-1:0] pic_address,
  output logic                       pic_chipselect,
  output logic                       pic_clken,
  input  logic [15:0]                pic_readdata,
  lt24_layer_streamer_if.master      lcd,
  output state_t                     dbg_state
);

  localparam int               PIC_AW    = SPR_WL2 + SPR_HL2;
  localparam logic [15:0]      HM1       = 16'(H_RES - 1);
  localparam logic [15:0]      VM1       = 16'(V_RES - 1);
  localparam logic [BG_AW-1:0] BG_STRIDE = BG_AW'(H_RES >> BG_SHIFT);

  // Header word {rs, data} for a given position in the command sequence.
  function automatic logic [16:0] hdr_word(input logic [3:0] idx);
    case (idx)
      4'd0:    hdr_word = {1'b0, 8'h00, CMD_CASET};
      4'd3:    hdr_word = {1'b1, 8'h00, HM1[15:8]};
      4'd4:    hdr_word = {1'b1, 8'h00, HM1[7:0]};
      4'd5:    hdr_word = {1'b0, 8'h00, CMD_PASET};
      4'd8:    hdr_word = {1'b1, 8'h00, VM1[15:8]};
      4'd9:    hdr_word = {1'b1, 8'h00, VM1[7:0]};
      4'd10:   hdr_word = {1'b0, 8'h00, CMD_RAMWR};
      default: hdr_word = {1'b1, 16'h0000};
    endcase
  endfunction

  state_t            state;
  logic              cs_n, ram_en, abort_q, last_px, hit_q;
  logic              spr_en_q;
  logic [8:0]        spr_x_q, spr_y_q;
  logic [15:0]       key_q;
  logic [3:0]        hdr_idx;
  logic [1:0]        wait_cnt;
  logic [9:0]        x, y;

  logic [9:0]        dx, dy;
  logic              hit_next;
  logic [PIC_AW-1:0] pic_next;
  logic [BG_AW-1:0]  bg_next;

  logic              abort_any, go, seq_next, px_load;
  logic              tm_load, tm_rs, lo_done, word_done;
  logic [15:0]       tm_data, pixel;
  logic [16:0]       hw;
  logic              tm_wr, tm_rs_o;
  logic [15:0]       tm_data_o;

  // Compositor addressing for the pixel at (x, y); the sprite clips, never wraps.
  always_comb begin
    dx       = x - {1'b0, spr_x_q};
    dy       = y - {1'b0, spr_y_q};
    hit_next = spr_en_q && (x >= {1'b0, spr_x_q}) && (y >= {1'b0, spr_y_q}) &&
               (dx < 10'(1 << SPR_WL2)) && (dy < 10'(1 << SPR_HL2));
    pic_next = {dy[SPR_HL2-1:0], dx[SPR_WL2-1:0]};
    bg_next  = BG_AW'(y >> BG_SHIFT) * BG_STRIDE + BG_AW'(x >> BG_SHIFT);
  end

  // Word-load selection: header table entry or composited pixel.
  always_comb begin
    abort_any = abort || abort_q;
    go        = (state == IDLE) && start && !abort;
    seq_next  = (state == SEQ) && word_done && !abort_any && (hdr_idx != 4'(HDR_LEN));
    px_load   = (state == PWAIT) && (wait_cnt == 2'd0);
    pixel     = (hit_q && (pic_readdata != key_q)) ? pic_readdata : bg_readdata;
    hw        = hdr_word(go ? 4'd0 : hdr_idx);
    tm_load   = go || seq_next || px_load;
    tm_rs     = px_load ? 1'b1 : hw[16];
    tm_data   = px_load ? pixel : hw[15:0];
  end

  // Frame sequencer with registered control outputs.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      cs_n        <= 1'b1;
      ram_en      <= 1'b0;
      abort_q     <= 1'b0;
      last_px     <= 1'b0;
      hit_q       <= 1'b0;
      spr_en_q    <= 1'b0;
      spr_x_q     <= 9'd0;
      spr_y_q     <= 9'd0;
      key_q       <= 16'd0;
      hdr_idx     <= 4'd0;
      wait_cnt    <= 2'd0;
      x           <= 10'd0;
      y           <= 10'd0;
      bg_address  <= '0;
      pic_address <= '0;
    end else begin
      done <= 1'b0;
      if (busy && abort) abort_q <= 1'b1;
      case (state)
        IDLE: begin
          if (go) begin
            state    <= SEQ;
            busy     <= 1'b1;
            cs_n     <= 1'b0;
            abort_q  <= 1'b0;
            hdr_idx  <= 4'd1;
            x        <= 10'd0;
            y        <= 10'd0;
            last_px  <= 1'b0;
            spr_en_q <= sprite_en;
            spr_x_q  <= sprite_x;
            spr_y_q  <= sprite_y;
            key_q    <= key_color;
          end
        end
        SEQ: begin
          if (word_done) begin
            if (abort_any) begin
              state <= FIN;
              cs_n  <= 1'b1;
              done  <= 1'b1;
            end else if (hdr_idx == 4'(HDR_LEN)) begin
              state       <= PADDR;
              bg_address  <= bg_next;
              pic_address <= pic_next;
              hit_q       <= hit_next;
              ram_en      <= 1'b1;
            end else begin
              hdr_idx <= hdr_idx + 4'd1;
            end
          end
        end
        PADDR: begin
          state    <= PWAIT;
          wait_cnt <= 2'(RD_LAT - 1);
        end
        PWAIT: begin
          if (wait_cnt == 2'd0) begin
            state   <= PWR_LO;
            ram_en  <= 1'b0;
            last_px <= (x == 10'(H_RES - 1)) && (y == 10'(V_RES - 1));
            if (x == 10'(H_RES - 1)) begin
              x <= 10'd0;
              y <= y + 10'd1;
            end else begin
              x <= x + 10'd1;
            end
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        PWR_LO: begin
          if (lo_done) state <= PWR_HI;
        end
        PWR_HI: begin
          if (word_done) begin
            if (abort_any || last_px) begin
              state <= FIN;
              cs_n  <= 1'b1;
              done  <= 1'b1;
            end else begin
              state       <= PADDR;
              bg_address  <= bg_next;
              pic_address <= pic_next;
              hit_q       <= hit_next;
              ram_en      <= 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  lt24_wr_timer #(
    .WR_LO_CYC (WR_LO_CYC),
    .WR_HI_CYC (WR_HI_CYC)
  ) u_wr_timer (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .load      (tm_load),
    .load_rs   (tm_rs),
    .load_data (tm_data),
    .wr        (tm_wr),
    .rs        (tm_rs_o),
    .data      (tm_data_o),
    .lo_done   (lo_done),
    .word_done (word_done)
  );

  assign lcd.lt24_cs   = cs_n;
  assign lcd.lt24_rd   = 1'b1;
  assign lcd.lt24_wr   = tm_wr;
  assign lcd.lt24_rs   = tm_rs_o;
  assign lcd.lt24_data = tm_data_o;

  assign bg_chipselect  = ram_en;
  assign bg_clken       = ram_en;
  assign pic_chipselect = ram_en;
  assign pic_clken      = ram_en;
  assign dbg_state      = state;

endmodule

// File: tb/tb_lt24_layer_streamer.sv
// Bench for lt24_layer_streamer at a reduced 8x4 frame with a 4x4 sprite.
module tb_lt24_layer_streamer;
  import lt24_pkg::*;

  localparam int W = 17;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start = 1'b0, abort = 1'b0, sprite_en = 1'b0;
  logic [8:0]  sprite_x = 9'd0, sprite_y = 9'd0;
  logic [15:0] key_color = 16'd0;
  logic        busy, done;
  logic [12:0] bg_address;
  logic        bg_chipselect, bg_clken;
  logic [15:0] bg_readdata;
  logic [3:0]  pic_address;
  logic        pic_chipselect, pic_clken;
  logic [15:0] pic_readdata;
  state_t      dbg_state;

  lt24_layer_streamer_if lcd();

  lt24_layer_streamer #(
    .H_RES(8), .V_RES(4), .BG_SHIFT(1), .BG_AW(13), .SPR_WL2(2), .SPR_HL2(2),
    .RD_LAT(2), .WR_LO_CYC(2), .WR_HI_CYC(2)
  ) dut (
    .clk_clk(clk), .reset_reset(rst), .start(start), .abort(abort),
    .sprite_en(sprite_en), .sprite_x(sprite_x), .sprite_y(sprite_y), .key_color(key_color),
    .busy(busy), .done(done),
    .bg_address(bg_address), .bg_chipselect(bg_chipselect), .bg_clken(bg_clken),
    .bg_readdata(bg_readdata),
    .pic_address(pic_address), .pic_chipselect(pic_chipselect), .pic_clken(pic_clken),
    .pic_readdata(pic_readdata),
    .lcd(lcd), .dbg_state(dbg_state)
  );

  // RAM models: 2-cycle latency, contents derived from the address.
  logic [15:0] bg_p1 = 16'd0, bg_p2 = 16'd0, pic_p1 = 16'd0, pic_p2 = 16'd0;
  always_ff @(posedge clk) begin
    if (bg_chipselect && bg_clken) begin
      bg_p1 <= 16'(bg_address);
      bg_p2 <= bg_p1;
    end
    if (pic_chipselect && pic_clken) begin
      pic_p1 <= 16'hF000 | 16'(pic_address);
      pic_p2 <= pic_p1;
    end
  end
  assign bg_readdata  = bg_p2;
  assign pic_readdata = pic_p2;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [16:0]  hdr_tbl [0:10] = '{17'h0002A, 17'h10000, 17'h10000, 17'h10000, 17'h10007,
                                   17'h0002B, 17'h10000, 17'h10000, 17'h10000, 17'h10003,
                                   17'h0002C};
  logic [15:0]  cap [32];
  int n_cmp = 0, n_err = 0;
  int wr_cnt = 0, word_idx = 0, hi_run = 0, done_cnt = 0, done_cyc = 0, cs_low_cnt = 0;
  int done_hi_run = 0, start_cyc = 0;
  logic done_cs = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(int x, int y, logic en, int sx, int sy, logic [15:0] key);
    logic [15:0] pic;
    int dx, dy;
    dx = x - sx;
    dy = y - sy;
    if (en && dx >= 0 && dy >= 0 && dx < 4 && dy < 4) begin
      pic = 16'hF000 | 16'(dy * 4 + dx);
      if (pic != key) return pic;
    end
    return 16'((y / 2) * 4 + x / 2);
  endfunction

  task automatic push_frame(input logic en, input int sx, input int sy,
                            input logic [15:0] key, input int npix);
    for (int i = 0; i < 11; i++) exp_q.push_back(hdr_tbl[i]);
    for (int p = 0; p < npix; p++)
      exp_q.push_back({1'b1, exp_pix(p % 8, p / 8, en, sx, sy, key)});
  endtask

  // Bus monitor: pops one expected word at every falling wr edge.
  task automatic monitor();
    logic        prev_wr;
    logic [16:0] got, want;
    prev_wr = 1'b1;
    forever begin
      @(negedge clk);
      if (prev_wr && !lcd.lt24_wr) begin
        got = {lcd.lt24_rs, lcd.lt24_data};
        wr_cnt++;
        check_eq("cs_low_at_write", 32'(lcd.lt24_cs), 32'd0);
        check_eq("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          check_eq($sformatf("word%0d", word_idx), 32'(got), 32'(want));
        end
        if (word_idx >= 11 && word_idx < 43) cap[word_idx - 11] = got[15:0];
        word_idx++;
      end
      hi_run  = lcd.lt24_wr ? hi_run + 1 : 0;
      prev_wr = lcd.lt24_wr;
      if (done) begin
        done_cnt++;
        done_cyc    = cyc;
        done_hi_run = hi_run;
        done_cs     = lcd.lt24_cs;
      end
      if (!lcd.lt24_cs) cs_low_cnt++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic with_abort, output int at_cyc);
    @(posedge clk); #1;
    start = 1'b1;
    abort = with_abort;
    @(posedge clk); #1;
    at_cyc = cyc;
    start  = 1'b0;
    abort  = 1'b0;
  endtask

  task automatic wait_done(input int dn0, input int limit);
    int n = 0;
    while (done_cnt == dn0 && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("done_within_bound", 32'(done_cnt != dn0), 32'd1);
  endtask

  task automatic wait_writes(input int target, input int limit);
    int n = 0;
    while (wr_cnt < target && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("writes_within_bound", 32'(wr_cnt >= target), 32'd1);
  endtask

  task automatic run_frame(input string tag, input logic en, input int sx, input int sy,
                           input logic [15:0] key);
    int wr0, dn0;
    sprite_en = en;
    sprite_x  = 9'(sx);
    sprite_y  = 9'(sy);
    key_color = key;
    push_frame(en, sx, sy, key, 32);
    wr0 = wr_cnt;
    dn0 = done_cnt;
    word_idx = 0;
    pulse_start(1'b0, start_cyc);
    wait_done(dn0, 600);
    check_eq({tag, "_latency"}, 32'(done_cyc - start_cyc), 32'd268);
    check_eq({tag, "_writes"}, 32'(wr_cnt - wr0), 32'd43);
    check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_cs_high_at_done"}, 32'(done_cs), 32'd1);
    check_eq({tag, "_hi_phase_at_done"}, 32'(done_hi_run), 32'd3);
    @(negedge clk); #1;
    check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
    check_eq({tag, "_done_once"}, 32'(done_cnt - dn0), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int viol, wr0, dn0, cl0, dummy;
    fork monitor(); join_none

    // 1: reset values, then 100 idle cycles
    repeat (3) @(negedge clk);
    check_eq("rst_cs", 32'(lcd.lt24_cs), 32'd1);
    check_eq("rst_rs", 32'(lcd.lt24_rs), 32'd1);
    check_eq("rst_rd", 32'(lcd.lt24_rd), 32'd1);
    check_eq("rst_wr", 32'(lcd.lt24_wr), 32'd1);
    check_eq("rst_data", 32'(lcd.lt24_data), 32'd0);
    check_eq("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check_eq("rst_addr", {15'd0, bg_address, pic_address}, 32'd0);
    check_eq("rst_ram_en", {28'd0, bg_chipselect, bg_clken, pic_chipselect, pic_clken}, 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (lcd.lt24_cs !== 1'b1 || lcd.lt24_wr !== 1'b1 || lcd.lt24_rd !== 1'b1 ||
          busy !== 1'b0 || bg_chipselect !== 1'b0 || pic_chipselect !== 1'b0) viol++;
    end
    check_eq("idle_100_cycles", 32'(viol), 32'd0);

    // 2: background-only frame
    run_frame("bg_frame", 1'b0, 0, 0, 16'h0000);
    check_eq("bg_px_0_0", 32'(cap[0]), 32'h0000);
    check_eq("bg_px_7_3", 32'(cap[31]), 32'h0007);

    // 3: sprite at (6,2), partly clipped, key colour 0xF005
    run_frame("spr_frame", 1'b1, 6, 2, 16'hF005);
    check_eq("spr_px_6_2", 32'(cap[2*8+6]), 32'hF000);
    check_eq("spr_px_7_2", 32'(cap[2*8+7]), 32'hF001);
    check_eq("spr_px_6_3", 32'(cap[3*8+6]), 32'hF004);
    check_eq("spr_px_7_3_keyed", 32'(cap[3*8+7]), 32'h0007);
    check_eq("spr_px_5_2_bg", 32'(cap[2*8+5]), 32'h0006);

    // 4: abort while the 10th pixel word has wr low
    sprite_en = 1'b0;
    push_frame(1'b0, 0, 0, 16'h0000, 10);
    wr0 = wr_cnt;
    dn0 = done_cnt;
    word_idx = 0;
    pulse_start(1'b0, start_cyc);
    wait_writes(wr0 + 21, 400);
    check_eq("abort_wr_low", 32'(lcd.lt24_wr), 32'd0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(dn0, 50);
    check_eq("abort_cs_high_at_done", 32'(done_cs), 32'd1);
    check_eq("abort_hi_phase_done", 32'(done_hi_run), 32'd3);
    repeat (20) @(negedge clk);
    #1;
    check_eq("abort_writes", 32'(wr_cnt - wr0), 32'd21);
    check_eq("abort_done_once", 32'(done_cnt - dn0), 32'd1);
    check_eq("abort_drained", 32'(exp_q.size()), 32'd0);
    check_eq("abort_busy_after", 32'(busy), 32'd0);

    // 5a: start while busy is ignored
    sprite_en = 1'b1;
    sprite_x  = 9'd1;
    sprite_y  = 9'd1;
    key_color = 16'hF000;
    push_frame(1'b1, 1, 1, 16'hF000, 32);
    wr0 = wr_cnt;
    dn0 = done_cnt;
    word_idx = 0;
    pulse_start(1'b0, start_cyc);
    wait_writes(wr0 + 5, 100);
    pulse_start(1'b0, dummy);
    wait_done(dn0, 600);
    check_eq("busy_start_latency", 32'(done_cyc - start_cyc), 32'd268);
    check_eq("busy_start_writes", 32'(wr_cnt - wr0), 32'd43);
    check_eq("busy_start_drained", 32'(exp_q.size()), 32'd0);
    repeat (30) @(negedge clk);
    #1;
    check_eq("busy_start_no_restart", 32'(wr_cnt - wr0), 32'd43);

    // 5b: start and abort together in IDLE
    wr0 = wr_cnt;
    dn0 = done_cnt;
    cl0 = cs_low_cnt;
    pulse_start(1'b1, dummy);
    repeat (40) @(negedge clk);
    #1;
    check_eq("start_abort_no_done", 32'(done_cnt - dn0), 32'd0);
    check_eq("start_abort_no_write", 32'(wr_cnt - wr0), 32'd0);
    check_eq("start_abort_no_cs", 32'(cs_low_cnt - cl0), 32'd0);
    check_eq("start_abort_busy", 32'(busy), 32'd0);

    // 6: asynchronous reset mid-frame, then a fresh frame
    push_frame(1'b1, 2, 0, 16'h1234, 32);
    wr0 = wr_cnt;
    word_idx = 0;
    sprite_x = 9'd2;
    sprite_y = 9'd0;
    key_color = 16'h1234;
    pulse_start(1'b0, start_cyc);
    wait_writes(wr0 + 20, 400);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_eq("arst_cs", 32'(lcd.lt24_cs), 32'd1);
    check_eq("arst_wr_rs", {30'd0, lcd.lt24_wr, lcd.lt24_rs}, 32'd3);
    check_eq("arst_data", 32'(lcd.lt24_data), 32'd0);
    check_eq("arst_busy_done", {30'd0, busy, done}, 32'd0);
    check_eq("arst_ram", {15'd0, bg_address, pic_address}, 32'd0);
    check_eq("arst_ram_en", {30'd0, bg_chipselect, pic_clken}, 32'd0);
    check_eq("arst_state", 32'(dbg_state), 32'(IDLE));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    run_frame("post_reset", 1'b1, 2, 0, 16'hF001);
    check_eq("post_reset_px_2_0", 32'(cap[2]), 32'hF000);
    check_eq("post_reset_px_3_0_keyed", 32'(cap[3]), 32'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
